// File: rtl/pzcorebus_request_mux_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// pzcorebus_request_mux_scheduler_pkg
//
// Shared definitions for the request-mux scheduler:
//   - pzbcm_selector_type : encoding of the select buses (one-hot or binary)
//   - calc_select_width   : width of a select bus for a given encoding/fan-in
//   - calc_index_width    : width of a requester index (minimum 1 bit)
//   - select_bit          : one bit of the encoded select for a given index,
//                           so callers can build any select width bit by bit
// ----------------------------------------------------------------------------
package pzcorebus_request_mux_scheduler_pkg;

    typedef enum logic {
        PZBCM_SELECTOR_ONEHOT = 1'b0,
        PZBCM_SELECTOR_BINARY = 1'b1
    } pzbcm_selector_type;

    function automatic int calc_select_width(pzbcm_selector_type selector_type, int entries);
        if (selector_type == PZBCM_SELECTOR_ONEHOT) begin
            return entries;
        end
        else if (entries <= 2) begin
            return 1;
        end
        else begin
            return $clog2(entries);
        end
    endfunction

    function automatic int calc_index_width(int entries);
        if (entries <= 2) begin
            return 1;
        end
        else begin
            return $clog2(entries);
        end
    endfunction

    // Bit 'bit_pos' of the encoded select for requester 'index'.
    function automatic logic select_bit(pzbcm_selector_type selector_type, int index, int bit_pos);
        if (selector_type == PZBCM_SELECTOR_ONEHOT) begin
            return logic'(index == bit_pos);
        end
        else begin
            return logic'((index >> bit_pos) & 1);
        end
    endfunction

endpackage

// File: rtl/pzcorebus_request_order_fifo.sv
// ----------------------------------------------------------------------------
// pzcorebus_request_order_fifo
//
// Small synchronous FIFO holding requester indices of accepted write commands
// in command order. The head entry is available combinationally.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push           write i_push_data (ignored when full unless popping too)
//   i_push_data      index to store
//   i_pop            drop the head entry (ignored when empty)
//   o_head           current head entry
//   o_empty, o_full  status from the registered occupancy
// ----------------------------------------------------------------------------
module pzcorebus_request_order_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);
    localparam int PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int COUNT_WIDTH = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_reg;
    logic [PTR_WIDTH-1:0]   wr_ptr_next;
    logic [PTR_WIDTH-1:0]   rd_ptr_reg;
    logic [PTR_WIDTH-1:0]   rd_ptr_next;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic [COUNT_WIDTH-1:0] count_next;
    logic                   push_en;
    logic                   pop_en;

    assign o_empty = (count_reg == '0);
    assign o_full  = (count_reg == COUNT_WIDTH'(DEPTH));
    assign o_head  = mem[rd_ptr_reg];

    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    assign push_en = i_push && (!o_full || i_pop);
    assign pop_en  = i_pop && !o_empty;

    // Depth need not be a power of two, so wrap with an explicit compare.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_en) begin
            wr_ptr_next = (wr_ptr_reg == PTR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_WIDTH'(1);
        end
        if (pop_en) begin
            rd_ptr_next = (rd_ptr_reg == PTR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_WIDTH'(1);
        end
        if (push_en && !pop_en) begin
            count_next = count_reg + COUNT_WIDTH'(1);
        end
        else if (pop_en && !push_en) begin
            count_next = count_reg - COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end
        else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage carries no reset: entries are only visible through count_reg.
    always_ff @(posedge i_clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= i_push_data;
        end
    end

endmodule

// File: rtl/pzcorebus_request_mux_scheduler.sv
// ----------------------------------------------------------------------------
// pzcorebus_request_mux_scheduler
//
// Generates the command and write-data select signals for a request mux.
// Commands are arbitrated round-robin with a grant that locks until the
// command is accepted. The index of every accepted write command is queued so
// write data is steered to requesters in command order, one burst per entry.
//
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_mcmd_valid[SLAVES]         per-requester command valid
//   i_mcmd_with_data[SLAVES]     per-requester command carries write data
//   i_scmd_accept                downstream command accept
//   i_mdata_valid                muxed write-data valid
//   i_sdata_accept               downstream write-data accept
//   i_mdata_last                 muxed write-data last beat
//   o_command_select(_valid)     command select and grant-active flag
//   o_write_data_select(_valid)  write-data select and order-queue non-empty
//   o_data_fifo_full             order queue full
// ----------------------------------------------------------------------------
module pzcorebus_request_mux_scheduler
    import pzcorebus_request_mux_scheduler_pkg::*;
#(
    parameter int                 SLAVES          = 2,
    parameter pzbcm_selector_type SELECTOR_TYPE   = PZBCM_SELECTOR_ONEHOT,
    parameter int                 SELECT_WIDTH    = calc_select_width(SELECTOR_TYPE, SLAVES),
    parameter int                 DATA_FIFO_DEPTH = 4
)(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [SLAVES-1:0]       i_mcmd_valid,
    input  logic [SLAVES-1:0]       i_mcmd_with_data,
    input  logic                    i_scmd_accept,
    input  logic                    i_mdata_valid,
    input  logic                    i_sdata_accept,
    input  logic                    i_mdata_last,
    output logic [SELECT_WIDTH-1:0] o_command_select,
    output logic                    o_command_select_valid,
    output logic [SELECT_WIDTH-1:0] o_write_data_select,
    output logic                    o_write_data_select_valid,
    output logic                    o_data_fifo_full
);
    localparam int INDEX_WIDTH = calc_index_width(SLAVES);
    typedef logic [INDEX_WIDTH-1:0] index_t;

    logic [SLAVES-1:0] eligible;
    logic              found;
    index_t            found_index;
    index_t            cand;
    logic              grant_valid;
    index_t            grant_index;
    logic              cmd_fire;
    logic              data_last_fire;
    logic              fifo_push;
    logic              fifo_empty;
    logic              fifo_full;
    index_t            fifo_head;

    index_t            ptr_reg;
    index_t            ptr_next;
    logic              lock_reg;
    logic              lock_next;
    index_t            lock_index_reg;
    index_t            lock_index_next;

    // A full order queue masks only commands that would need a queue entry.
    genvar gi;
    generate
        for (gi = 0; gi < SLAVES; gi++) begin : g_eligible
            assign eligible[gi] = i_mcmd_valid[gi] && !(i_mcmd_with_data[gi] && fifo_full);
        end
    endgenerate

    // Round-robin search upward from the priority pointer, wrapping to 0.
    always_comb begin
        found       = 1'b0;
        found_index = '0;
        cand        = ptr_reg;
        for (int k = 0; k < SLAVES; k++) begin
            if (!found && eligible[cand]) begin
                found       = 1'b1;
                found_index = cand;
            end
            cand = (cand == INDEX_WIDTH'(SLAVES - 1)) ? '0 : cand + INDEX_WIDTH'(1);
        end
    end

    // A locked grant was qualified when first issued, so it bypasses eligibility.
    assign grant_valid = lock_reg || found;
    assign grant_index = lock_reg ? lock_index_reg : found_index;
    assign cmd_fire    = grant_valid && i_scmd_accept;
    assign fifo_push   = cmd_fire && i_mcmd_with_data[grant_index];

    assign data_last_fire = !fifo_empty && i_mdata_valid && i_sdata_accept && i_mdata_last;

    always_comb begin
        ptr_next        = ptr_reg;
        lock_next       = lock_reg;
        lock_index_next = lock_index_reg;
        if (cmd_fire) begin
            ptr_next  = (grant_index == INDEX_WIDTH'(SLAVES - 1)) ? '0 : grant_index + INDEX_WIDTH'(1);
            lock_next = 1'b0;
        end
        else if (grant_valid) begin
            lock_next       = 1'b1;
            lock_index_next = grant_index;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_reg        <= '0;
            lock_reg       <= 1'b0;
            lock_index_reg <= '0;
        end
        else begin
            ptr_reg        <= ptr_next;
            lock_reg       <= lock_next;
            lock_index_reg <= lock_index_next;
        end
    end

    pzcorebus_request_order_fifo #(
        .WIDTH (INDEX_WIDTH),
        .DEPTH (DATA_FIFO_DEPTH)
    ) u_order_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (fifo_push),
        .i_push_data (grant_index),
        .i_pop       (data_last_fire),
        .o_head      (fifo_head),
        .o_empty     (fifo_empty),
        .o_full      (fifo_full)
    );

    assign o_command_select_valid    = grant_valid;
    assign o_write_data_select_valid = !fifo_empty;
    assign o_data_fifo_full          = fifo_full;

    // Selects are forced to zero when invalid (all-zero one-hot, index 0 binary).
    generate
        for (gi = 0; gi < SELECT_WIDTH; gi++) begin : g_select
            assign o_command_select[gi]    = grant_valid
                                          && select_bit(SELECTOR_TYPE, int'(grant_index), gi);
            assign o_write_data_select[gi] = !fifo_empty
                                          && select_bit(SELECTOR_TYPE, int'(fifo_head), gi);
        end
    endgenerate

endmodule

// File: tb/tb_pzcorebus_request_mux_scheduler.sv
// ----------------------------------------------------------------------------
// tb_pzcorebus_request_mux_scheduler
//
// Directed bench: 4 requesters, one-hot selects, order queue depth 2.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ----------------------------------------------------------------------------
module tb_pzcorebus_request_mux_scheduler;
    import pzcorebus_request_mux_scheduler_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] mcmd_valid;
    logic [3:0] mcmd_with_data;
    logic       scmd_accept;
    logic       mdata_valid;
    logic       sdata_accept;
    logic       mdata_last;
    logic [3:0] cmd_sel;
    logic       cmd_sel_valid;
    logic [3:0] wd_sel;
    logic       wd_sel_valid;
    logic       fifo_full;

    int total;
    int bad;

    pzcorebus_request_mux_scheduler #(
        .SLAVES          (4),
        .SELECTOR_TYPE   (PZBCM_SELECTOR_ONEHOT),
        .SELECT_WIDTH    (4),
        .DATA_FIFO_DEPTH (2)
    ) dut (
        .i_clk                     (clk),
        .i_rst_n                   (rst_n),
        .i_mcmd_valid              (mcmd_valid),
        .i_mcmd_with_data          (mcmd_with_data),
        .i_scmd_accept             (scmd_accept),
        .i_mdata_valid             (mdata_valid),
        .i_sdata_accept            (sdata_accept),
        .i_mdata_last              (mdata_last),
        .o_command_select          (cmd_sel),
        .o_command_select_valid    (cmd_sel_valid),
        .o_write_data_select       (wd_sel),
        .o_write_data_select_valid (wd_sel_valid),
        .o_data_fifo_full          (fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] v, input logic [3:0] wd, input logic acc,
                         input logic dv, input logic dlast);
        mcmd_valid     = v;
        mcmd_with_data = wd;
        scmd_accept    = acc;
        mdata_valid    = dv;
        sdata_accept   = dv;
        mdata_last     = dlast;
    endtask

    task automatic show(input string name);
        $display("%0t %s: cmd_sel=%b/%b wd_sel=%b/%b full=%b", $time, name,
                 cmd_sel, cmd_sel_valid, wd_sel, wd_sel_valid, fifo_full);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        show("reset");
        total++; if (cmd_sel_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid got=%b want=0", cmd_sel_valid); end
        total++; if (cmd_sel !== 4'b0000) begin bad++; $display("FAIL reset_cmd_sel got=%b want=0000", cmd_sel); end
        total++; if (wd_sel_valid !== 1'b0) begin bad++; $display("FAIL reset_wd_valid got=%b want=0", wd_sel_valid); end
        total++; if (wd_sel !== 4'b0000) begin bad++; $display("FAIL reset_wd_sel got=%b want=0000", wd_sel); end
        total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", fifo_full); end
        rst_n = 1'b1;
        next_cycle();
    endtask

    // Pointer 0: requester 2 is held locked while requester 0 (higher priority
    // from pointer 0) is also requesting.
    task automatic test_lock();
        drive(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk); show("lock c0");
        total++; if (cmd_sel !== 4'b0100 || cmd_sel_valid !== 1'b1) begin bad++; $display("FAIL lock_c0 got=%b/%b want=0100/1", cmd_sel, cmd_sel_valid); end
        next_cycle();
        drive(4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk); show("lock c1");
        total++; if (cmd_sel !== 4'b0100) begin bad++; $display("FAIL lock_c1 got=%b want=0100", cmd_sel); end
        next_cycle();
        @(negedge clk); show("lock c2");
        total++; if (cmd_sel !== 4'b0100) begin bad++; $display("FAIL lock_c2 got=%b want=0100", cmd_sel); end
        next_cycle();
        drive(4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk); show("lock c3 accept");
        total++; if (cmd_sel !== 4'b0100) begin bad++; $display("FAIL lock_c3 got=%b want=0100", cmd_sel); end
        next_cycle();
        drive(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk); show("lock c4");
        total++; if (cmd_sel !== 4'b0001 || cmd_sel_valid !== 1'b1) begin bad++; $display("FAIL lock_after got=%b/%b want=0001/1", cmd_sel, cmd_sel_valid); end
        next_cycle();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk); show("lock idle");
        total++; if (cmd_sel_valid !== 1'b0) begin bad++; $display("FAIL lock_idle got=%b want=0", cmd_sel_valid); end
        next_cycle();
    endtask

    // Pointer 1: requesters 1 and 3 without data; then probe that pointer wrapped to 0.
    task automatic test_round_robin();
        drive(4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk); show("rr c0");
        total++; if (cmd_sel !== 4'b0010) begin bad++; $display("FAIL rr_first got=%b want=0010", cmd_sel); end
        next_cycle();
        drive(4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk); show("rr c1");
        total++; if (cmd_sel !== 4'b1000) begin bad++; $display("FAIL rr_second got=%b want=1000", cmd_sel); end
        next_cycle();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk); show("rr c2");
        total++; if (cmd_sel_valid !== 1'b0) begin bad++; $display("FAIL rr_idle got=%b want=0", cmd_sel_valid); end
        total++; if (wd_sel_valid !== 1'b0) begin bad++; $display("FAIL rr_fifo_empty got=%b want=0", wd_sel_valid); end
        next_cycle();
        drive(4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk); show("rr probe");
        total++; if (cmd_sel !== 4'b0001) begin bad++; $display("FAIL rr_ptr_wrap got=%b want=0001", cmd_sel); end
        next_cycle();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    // Pointer 1: writes from 2 then 0; bursts of 3 and 1 beats.
    task automatic test_write_order();
        drive(4'b0101, 4'b0101, 1'b1, 1'b0, 1'b0);
        @(negedge clk); show("wo c0");
        total++; if (cmd_sel !== 4'b0100) begin bad++; $display("FAIL wo_cmd2 got=%b want=0100", cmd_sel); end
        total++; if (wd_sel_valid !== 1'b0) begin bad++; $display("FAIL wo_no_bypass got=%b want=0", wd_sel_valid); end
        next_cycle();
        drive(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
        @(negedge clk); show("wo c1");
        total++; if (cmd_sel !== 4'b0001) begin bad++; $display("FAIL wo_cmd0 got=%b want=0001", cmd_sel); end
        total++; if (wd_sel !== 4'b0100 || wd_sel_valid !== 1'b1) begin bad++; $display("FAIL wo_wd_first got=%b/%b want=0100/1", wd_sel, wd_sel_valid); end
        next_cycle();
        for (int beat = 1; beat <= 3; beat++) begin
            drive(4'b0000, 4'b0000, 1'b0, 1'b1, logic'(beat == 3));
            @(negedge clk); show($sformatf("wo beat %0d", beat));
            total++; if (wd_sel !== 4'b0100) begin bad++; $display("FAIL wo_beat%0d got=%b want=0100", beat, wd_sel); end
            if (beat == 1) begin
                total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL wo_full got=%b want=1", fifo_full); end
            end
            next_cycle();
        end
        drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
        @(negedge clk); show("wo beat 4");
        total++; if (wd_sel !== 4'b0001 || wd_sel_valid !== 1'b1) begin bad++; $display("FAIL wo_second got=%b/%b want=0001/1", wd_sel, wd_sel_valid); end
        next_cycle();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk); show("wo drained");
        total++; if (wd_sel_valid !== 1'b0 || wd_sel !== 4'b0000) begin bad++; $display("FAIL wo_drained got=%b/%b want=0000/0", wd_sel, wd_sel_valid); end
        next_cycle();
    endtask

    // Pointer 1: fill the queue from requester 1, show masking, then release.
    task automatic test_fifo_full();
        drive(4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0);
        @(negedge clk); show("ff c0");
        total++; if (cmd_sel !== 4'b0010) begin bad++; $display("FAIL ff_w1 got=%b want=0010", cmd_sel); end
        next_cycle();
        @(negedge clk); show("ff c1");
        total++; if (cmd_sel !== 4'b0010) begin bad++; $display("FAIL ff_w2 got=%b want=0010", cmd_sel); end
        next_cycle();
        drive(4'b1010, 4'b0010, 1'b1, 1'b0, 1'b0);
        @(negedge clk); show("ff c2");
        total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL ff_full got=%b want=1", fifo_full); end
        total++; if (cmd_sel !== 4'b1000) begin bad++; $display("FAIL ff_nodata_granted got=%b want=1000", cmd_sel); end
        next_cycle();
        drive(4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0);
        @(negedge clk); show("ff c3");
        total++; if (cmd_sel_valid !== 1'b0) begin bad++; $display("FAIL ff_masked got=%b want=0", cmd_sel_valid); end
        next_cycle();
        drive(4'b0010, 4'b0010, 1'b1, 1'b1, 1'b1);
        @(negedge clk); show("ff c4 pop");
        total++; if (cmd_sel_valid !== 1'b0) begin bad++; $display("FAIL ff_masked_pop got=%b want=0", cmd_sel_valid); end
        next_cycle();
        // Write granted right after the pop, with another pop in the same cycle.
        drive(4'b0010, 4'b0010, 1'b1, 1'b1, 1'b1);
        @(negedge clk); show("ff c5 push+pop");
        total++; if (cmd_sel !== 4'b0010 || cmd_sel_valid !== 1'b1) begin bad++; $display("FAIL ff_regrant got=%b/%b want=0010/1", cmd_sel, cmd_sel_valid); end
        next_cycle();
        drive(4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0);
        @(negedge clk); show("ff c6");
        total++; if (fifo_full !== 1'b0 || wd_sel !== 4'b0010) begin bad++; $display("FAIL ff_occ_one got=%b/%b want=0/0010", fifo_full, wd_sel); end
        next_cycle();
        drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
        @(negedge clk); show("ff c7");
        total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL ff_refull got=%b want=1", fifo_full); end
        next_cycle();
        @(negedge clk); show("ff c8");
        total++; if (fifo_full !== 1'b0 || wd_sel_valid !== 1'b1) begin bad++; $display("FAIL ff_drain1 got=%b/%b want=0/1", fifo_full, wd_sel_valid); end
        next_cycle();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk); show("ff c9");
        total++; if (wd_sel_valid !== 1'b0) begin bad++; $display("FAIL ff_drain2 got=%b want=0", wd_sel_valid); end
        next_cycle();
    endtask

    // Pointer 2: two writes queued, no-data grant locked on 2, reset mid-burst.
    task automatic test_async_reset();
        drive(4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0);
        @(negedge clk); show("ar c0");
        total++; if (cmd_sel !== 4'b1000) begin bad++; $display("FAIL ar_w3 got=%b want=1000", cmd_sel); end
        next_cycle();
        drive(4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0);
        @(negedge clk); show("ar c1");
        total++; if (cmd_sel !== 4'b0010) begin bad++; $display("FAIL ar_w1 got=%b want=0010", cmd_sel); end
        next_cycle();
        drive(4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk); show("ar c2");
        total++; if (cmd_sel !== 4'b0100 || wd_sel !== 4'b1000 || fifo_full !== 1'b1) begin bad++; $display("FAIL ar_setup got=%b/%b/%b want=0100/1000/1", cmd_sel, wd_sel, fifo_full); end
        next_cycle();
        #1;
        rst_n = 1'b0;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        #1;
        show("ar in reset");
        total++; if (cmd_sel_valid !== 1'b0 || cmd_sel !== 4'b0000) begin bad++; $display("FAIL ar_cmd got=%b/%b want=0000/0", cmd_sel, cmd_sel_valid); end
        total++; if (wd_sel_valid !== 1'b0 || wd_sel !== 4'b0000 || fifo_full !== 1'b0) begin bad++; $display("FAIL ar_wd got=%b/%b/%b want=0000/0/0", wd_sel, wd_sel_valid, fifo_full); end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        drive(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk); show("ar restart");
        total++; if (cmd_sel !== 4'b0001) begin bad++; $display("FAIL ar_ptr0 got=%b want=0001", cmd_sel); end
        next_cycle();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_lock();
        test_round_robin();
        test_write_order();
        test_fifo_full();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end

endmodule

// File: doc/pzcorebus_request_mux_scheduler.md
Name: pzcorebus_request_mux_scheduler

Overview:
- Arbitration and sequencing controller that generates i_command_select / i_write_data_select for pzcorebus_request_mux.
- Round-robin arbitration of command requests from SLAVES requesters; grant holds until the command handshake completes.
- Each accepted write (with-data) command's grant index is recorded in an order FIFO, so the write-data channel is steered to requesters in command order, one burst per entry, popped on the last beat.

Parameters:
- SLAVES, 2, number of requesters (>=2)
- SELECTOR_TYPE, PZBCM_SELECTOR_ONEHOT, ONEHOT or BINARY encoding of select outputs
- SELECT_WIDTH, calc_select_width(SELECTOR_TYPE, SLAVES), select output width
- DATA_FIFO_DEPTH, 4, outstanding write commands awaiting data (>=1)

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_mcmd_valid  input  SLAVES  per-requester command valid
- i_mcmd_with_data  input  SLAVES  per-requester: pending command carries write data; qualified by i_mcmd_valid
- i_scmd_accept  input  1  downstream (master side) command accept
- i_mdata_valid  input  1  master-side muxed write-data valid
- i_sdata_accept  input  1  master-side write-data accept
- i_mdata_last  input  1  master-side muxed last-beat flag
- o_command_select  output  SELECT_WIDTH  command select to mux
- o_command_select_valid  output  1  a command grant is active
- o_write_data_select  output  SELECT_WIDTH  write-data select to mux
- o_write_data_select_valid  output  1  order FIFO non-empty
- o_data_fifo_full  output  1  status: order FIFO full

Behaviour:
- Reset state:
  - priority pointer = 0, lock = 0, FIFO empty.
  - o_command_select_valid = 0, o_write_data_select_valid = 0, o_data_fifo_full = 0.
  - Both selects = 0.
- Eligibility: requester i is eligible when i_mcmd_valid[i] and NOT (i_mcmd_with_data[i] and FIFO full). Full FIFO masks only with-data commands; no-data commands still arbitrate.
- Arbitration is combinational (zero latency) when unlocked:
  - Grant the first eligible index searching upward from the pointer, wrapping at SLAVES-1 to 0.
  - No eligible requester: o_command_select_valid = 0.
- Command handshake: cmd_fire = o_command_select_valid and i_scmd_accept.
  - On fire, pointer <= (granted index + 1) mod SLAVES and lock <= 0.
- Lock:
  - If granted and not accepted, register lock = 1 plus the locked index.
  - While locked, the grant stays on the locked index regardless of other requests, and regardless of FIFO full (eligibility was checked at grant time).
  - Lock is held until fire. Requesters must not drop valid; no recovery is defined.
- Order FIFO push: cmd_fire with i_mcmd_with_data[granted] = 1 pushes the granted index.
- Order FIFO pop: data_last_fire = o_write_data_select_valid and i_mdata_valid and i_sdata_accept and i_mdata_last.
- o_write_data_select comes from the FIFO head only.
  - Data for a command is steerable from the cycle after its command fire (no bypass).
- Simultaneous push and pop:
  - When full: allowed; occupancy stays unchanged.
  - When empty: impossible, because the head is invalid.
- Select encoding when invalid:
  - ONEHOT: all-zero, so the mux forwards valid = 0.
  - BINARY: 0; the integrator must gate mux valid with *_select_valid.
- o_data_fifo_full: combinational from registered occupancy == DATA_FIFO_DEPTH.
- Asynchronous reset mid-transfer discards the lock and all FIFO entries immediately; all outputs return to their reset values.
- Width rules:
  - FIFO entries are clog2(SLAVES) bits wide, minimum 1.
  - Occupancy counter is clog2(DATA_FIFO_DEPTH+1) bits.
  - Pointer wrap uses an explicit compare, not a power-of-2 mask.

Decomposition:
- Shared package holds:
  - an index typedef sized by SLAVES;
  - a helper converting an index to SELECT_WIDTH per SELECTOR_TYPE (reuses calc_select_width from pzbcm_selector_pkg).
- One natural sub-module: pzcorebus_request_order_fifo, a synchronous FIFO of index entries with push/pop/full/empty and a head output.
- The round-robin arbiter stays inline.

Test Plan:
- SLAVES=4, requesters 1 and 3 valid with no data, accept held 1 → grants 1 then 3 on consecutive cycles; pointer ends at 0; FIFO stays empty.
- Requester 2 valid with accept = 0 for 3 cycles, requester 0 raised at cycle 1 → select stays 2 (onehot 0100) until accept, then 0 is granted.
- Writes from requesters 2 then 0 accepted back-to-back; data bursts of 3 and 1 beats → write_data_select = 2 for beats 1-3 (pop on the last beat), then 0; select_valid drops after the final last beat.
- DATA_FIFO_DEPTH=2: three write commands from requester 1 plus a no-data command from requester 3 → third write is masked; o_data_fifo_full = 1; requester 3 is granted; the write is granted the cycle after the first last-beat pop.
- FIFO full, push and pop in the same cycle → occupancy remains 2 and order is preserved.
- Assert i_rst_n = 0 mid-burst with 2 FIFO entries and lock set → all outputs reach reset values asynchronously; the next arbitration starts from pointer 0.
